axi_stream_master_tx: RTL and testbench
=======================================

AXI_STREAM_MASTER_TX -- requirements
Module: axi_stream_master_tx

Interface
REQ-001 SHALL have parameter C_M_AXIS_TDATA_WIDTH, default 32, stream data width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, internal buffer depth in words (power of two, >=2).
REQ-003 SHALL have parameter PKT_GAP, default 2, idle cycles forced after each tlast beat (0 = none).
REQ-004 SHALL have one clock and an asynchronous, active-high reset; all logic on the rising edge of m00_axis_aclk.
REQ-005 m00_axis_aclk  input  1  clock.
REQ-006 m00_axis_areset  input  1  asynchronous active-high reset.
REQ-007 in_wr_en  input  1  write request for one word.
REQ-008 in_wr_data  input  C_M_AXIS_TDATA_WIDTH  word to buffer.
REQ-009 in_wr_last  input  1  word is the last of a packet.
REQ-010 in_full  output  1  buffer full; writes are not accepted.
REQ-011 in_count  output  clog2(FIFO_DEPTH)+1  words held in the buffer, excluding the output register.
REQ-012 in_overflow  output  1  sticky flag: a write arrived while in_full.
REQ-013 m00_axis_tvalid  output  1  beat valid.
REQ-014 m00_axis_tready  input  1  downstream ready.
REQ-015 m00_axis_tdata  output  C_M_AXIS_TDATA_WIDTH  beat data.
REQ-016 m00_axis_tstrb  output  C_M_AXIS_TDATA_WIDTH/8  byte strobes, constant all ones.
REQ-017 m00_axis_tlast  output  1  last beat of packet.

Function
REQ-018 The buffer SHALL be a circular FIFO of FIFO_DEPTH entries, each {last, data}; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 A write SHALL be accepted iff in_wr_en && !in_full; in_full SHALL equal (in_count == FIFO_DEPTH), registered.
REQ-020 A write while in_full SHALL be dropped and SHALL set in_overflow, even if a pop occurs in the same cycle.
REQ-021 A simultaneous accepted write and pop SHALL leave in_count unchanged.
REQ-022 tvalid, tdata and tlast SHALL be driven from an output register; earliest latency is a write in cycle N, tvalid high in cycle N+1.
REQ-023 FSM states SHALL be IDLE (output register empty), VALID (beat presented) and GAP (post-packet idle).
REQ-024 IDLE: if FIFO is non-empty, pop head into output register and enter VALID; otherwise stay.
REQ-025 VALID: tvalid=1; tdata/tlast SHALL remain stable until tvalid && tready.
REQ-026 VALID on handshake with tlast=1 and PKT_GAP>0: clear tvalid, load gap counter 0, enter GAP.
REQ-027 VALID on handshake otherwise: if FIFO non-empty, pop next word the same cycle (back-to-back beats, no bubble); else enter IDLE with tvalid=0.
REQ-028 GAP: tvalid=0 for exactly PKT_GAP cycles; on the last gap cycle pop head into VALID if FIFO non-empty, else enter IDLE.
REQ-029 tvalid SHALL never depend combinationally on tready; tvalid SHALL not deassert without a handshake.
REQ-030 Packets SHALL be delimited solely by in_wr_last; no length limit; a word with in_wr_last=0 followed by an empty FIFO SHALL simply wait.

Reset
REQ-031 On m00_axis_areset high, asynchronously: tvalid=0, tdata=0, tlast=0, in_count=0, in_full=0, in_overflow=0, pointers=0, state=IDLE.
REQ-032 Reset mid-packet SHALL discard all buffered and presented words; no beat SHALL appear until a new write after reset release.
REQ-033 m00_axis_tstrb SHALL be all ones during and after reset.

Verification
REQ-034 Write 0xA0..0xA3 (last on 0xA3), tready=1 -> beats A0,A1,A2,A3 on consecutive cycles, first one cycle after first write; tlast only on A3.
REQ-035 Two 2-word packets queued, tready=1, PKT_GAP=2 -> exactly 2 tvalid-low cycles between the tlast beat and the first beat of packet 2.
REQ-036 tready asserted one cycle in every 16 -> each beat held stable 16 cycles, no loss or duplication, order preserved.
REQ-037 tready=0, write 17 words into FIFO_DEPTH=16 -> first word in output register, 16 buffered, in_full=1 at the 17th accepted write; an 18th write sets in_overflow, in_count stays 16.
REQ-038 Assert reset while a beat is held (tready=0) -> tvalid=0 immediately, in_count=0; after release, no beat until a new write.
REQ-039 Simultaneous write and pop with in_count=5 -> in_count stays 5; pointer wrap exercised past 16 writes with data intact.

Source files
------------

// File: rtl/axi_stream_master_tx.sv
// AXI4-Stream master fed by a write-side circular FIFO, with one output
// register and an optional forced idle gap after each tlast beat.
module axi_stream_master_tx #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int PKT_GAP              = 2
) (
    input  logic                                m00_axis_aclk,
    input  logic                                m00_axis_areset,

    input  logic                                in_wr_en,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     in_wr_data,
    input  logic                                in_wr_last,
    output logic                                in_full,
    output logic [$clog2(FIFO_DEPTH):0]         in_count,
    output logic                                in_overflow,

    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                m00_axis_tlast
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (PKT_GAP > 1) ? $clog2(PKT_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((PKT_GAP > 0) ? PKT_GAP - 1 : 0);

    typedef struct packed {
        logic                            last;
        logic [C_M_AXIS_TDATA_WIDTH-1:0] data;
    } word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VALID,
        S_GAP
    } state_t;

    word_t          mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           full;
    logic           overflow;

    state_t         state;
    state_t         state_next;
    logic [GW-1:0]  gap_cnt;
    word_t          out_word;

    word_t          in_word;
    word_t          head;
    logic           push;
    logic           fifo_empty;
    logic           avail;
    logic           load;
    logic           bypass;
    logic           fifo_wr;
    logic           fifo_rd;
    logic           gap_clr;
    logic           gap_inc;

    assign in_word    = {in_wr_last, in_wr_data};
    assign push       = in_wr_en && !full;
    assign fifo_empty = (count == '0);

    // An empty FIFO lets an incoming write go straight to the output register,
    // giving one-cycle latency and bubble-free streaming of live writes.
    assign avail   = !fifo_empty || push;
    assign head    = fifo_empty ? in_word : mem[rd_ptr];
    assign bypass  = load && fifo_empty;
    assign fifo_wr = push && !bypass;
    assign fifo_rd = load && !fifo_empty;

    always_comb begin
        case ({fifo_wr, fifo_rd})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of block order.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + AW'(1);
            if (fifo_rd) rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            full     <= (count_next == CW'(FIFO_DEPTH));
            overflow <= overflow || (in_wr_en && full);
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge m00_axis_aclk) begin
        if (fifo_wr) mem[wr_ptr] <= in_word;
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        gap_clr    = 1'b0;
        gap_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (avail) begin
                    load       = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                if (m00_axis_tready) begin
                    if (out_word.last && (PKT_GAP > 0)) begin
                        gap_clr    = 1'b1;
                        state_next = S_GAP;
                    end else if (avail) begin
                        load = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (avail) begin
                        load       = 1'b1;
                        state_next = S_VALID;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    gap_inc = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state    <= S_IDLE;
            gap_cnt  <= '0;
            out_word <= '0;
        end else begin
            state <= state_next;
            if (gap_clr)      gap_cnt <= '0;
            else if (gap_inc) gap_cnt <= gap_cnt + GW'(1);
            if (load) out_word <= head;
        end
    end

    // tvalid is a pure decode of the state register, never of tready.
    assign m00_axis_tvalid = (state == S_VALID);
    assign m00_axis_tdata  = out_word.data;
    assign m00_axis_tlast  = out_word.last;
    assign m00_axis_tstrb  = '1;

    assign in_full     = full;
    assign in_count    = count;
    assign in_overflow = overflow;

endmodule

// File: tb/tb_axi_stream_master_tx.sv
// Directed bench for axi_stream_master_tx with default parameters
// (32-bit data, 16-deep buffer, 2-cycle packet gap).
module tb_axi_stream_master_tx;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic           m00_axis_aclk   = 1'b0;
    logic           m00_axis_areset = 1'b1;
    logic           in_wr_en        = 1'b0;
    logic [W-1:0]   in_wr_data      = '0;
    logic           in_wr_last      = 1'b0;
    logic           m00_axis_tready = 1'b0;
    logic           in_full;
    logic [CW-1:0]  in_count;
    logic           in_overflow;
    logic           m00_axis_tvalid;
    logic [W-1:0]   m00_axis_tdata;
    logic [W/8-1:0] m00_axis_tstrb;
    logic           m00_axis_tlast;

    int n_vec = 0;
    int n_bad = 0;

    axi_stream_master_tx #(
        .C_M_AXIS_TDATA_WIDTH (W),
        .FIFO_DEPTH           (DEPTH),
        .PKT_GAP              (2)
    ) dut (
        .m00_axis_aclk   (m00_axis_aclk),
        .m00_axis_areset (m00_axis_areset),
        .in_wr_en        (in_wr_en),
        .in_wr_data      (in_wr_data),
        .in_wr_last      (in_wr_last),
        .in_full         (in_full),
        .in_count        (in_count),
        .in_overflow     (in_overflow),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tstrb  (m00_axis_tstrb),
        .m00_axis_tlast  (m00_axis_tlast)
    );

    always #5 m00_axis_aclk = ~m00_axis_aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge m00_axis_aclk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d, input logic l);
        in_wr_en   = 1'b1;
        in_wr_data = d;
        in_wr_last = l;
        step();
        in_wr_en   = 1'b0;
        in_wr_last = 1'b0;
    endtask

    initial begin
        logic       exp_v [6];
        logic [31:0] exp_d [6];
        logic       exp_l [6];
        logic [31:0] d_words [3];
        int bad;
        int gap_lows;

        exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_d = '{32'hB1, 32'h0, 32'h0, 32'hC0, 32'hC1, 32'h0};
        exp_l = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        d_words = '{32'hD0, 32'hD1, 32'hD2};

        // Reset state
        #2;
        check("rst_tvalid",   32'(m00_axis_tvalid), 32'd0);
        check("rst_tdata",    m00_axis_tdata,       32'd0);
        check("rst_tlast",    32'(m00_axis_tlast),  32'd0);
        check("rst_count",    32'(in_count),        32'd0);
        check("rst_full",     32'(in_full),         32'd0);
        check("rst_overflow", 32'(in_overflow),     32'd0);
        check("rst_tstrb",    32'(m00_axis_tstrb),  32'hF);
        repeat (2) step();
        m00_axis_areset = 1'b0;
        step();
        check("idle_after_release", 32'(m00_axis_tvalid), 32'd0);

        // A0..A3 streamed with tready high: one beat per cycle, 1-cycle latency
        m00_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_wr_en   = 1'b1;
            in_wr_data = 32'hA0 + i;
            in_wr_last = (i == 3);
            step();
            check("stream_tvalid", 32'(m00_axis_tvalid), 32'd1);
            check("stream_tdata",  m00_axis_tdata,       32'hA0 + i);
            check("stream_tlast",  32'(m00_axis_tlast),  32'(i == 3));
        end
        in_wr_en   = 1'b0;
        in_wr_last = 1'b0;
        step();
        check("stream_gap_tvalid", 32'(m00_axis_tvalid), 32'd0);
        check("stream_count",      32'(in_count),        32'd0);
        repeat (2) step();

        // Two queued 2-word packets: exactly 2 idle cycles between them
        m00_axis_tready = 1'b0;
        write_word(32'hB0, 1'b0);
        write_word(32'hB1, 1'b1);
        write_word(32'hC0, 1'b0);
        write_word(32'hC1, 1'b1);
        check("pkt_count_queued", 32'(in_count),        32'd3);
        check("pkt_first_held",   m00_axis_tdata,       32'hB0);
        m00_axis_tready = 1'b1;
        gap_lows = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("pkt_tvalid", 32'(m00_axis_tvalid), 32'(exp_v[i]));
            if (exp_v[i]) begin
                check("pkt_tdata", m00_axis_tdata,      exp_d[i]);
                check("pkt_tlast", 32'(m00_axis_tlast), 32'(exp_l[i]));
            end
            if (i > 0 && i < 3 && !m00_axis_tvalid) gap_lows++;
        end
        check("pkt_gap_len", 32'(gap_lows), 32'd2);
        repeat (2) step();

        // tready once every 16 cycles: each beat held stable, no loss or dup
        m00_axis_tready = 1'b0;
        write_word(d_words[0], 1'b0);
        write_word(d_words[1], 1'b0);
        write_word(d_words[2], 1'b1);
        for (int k = 0; k < 3; k++) begin
            bad = 0;
            for (int j = 0; j < 16; j++) begin
                m00_axis_tready = (j == 15);
                if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== d_words[k] ||
                    m00_axis_tlast !== (k == 2))
                    bad++;
                step();
            end
            check("slow_hold_beat", 32'(bad), 32'd0);
        end
        m00_axis_tready = 1'b0;
        check("slow_no_dup",  32'(m00_axis_tvalid), 32'd0);
        check("slow_count",   32'(in_count),        32'd0);
        repeat (3) step();

        // Fill: 17 words (1 presented + 16 buffered), then an overflow write
        for (int i = 0; i < 17; i++) begin
            write_word(32'hE00 + i, (i == 16));
            if (i == 15) begin
                check("fill15_count", 32'(in_count), 32'd15);
                check("fill15_full",  32'(in_full),  32'd0);
            end
        end
        check("fill_count",    32'(in_count),    32'd16);
        check("fill_full",     32'(in_full),     32'd1);
        check("fill_overflow", 32'(in_overflow), 32'd0);
        check("fill_head",     m00_axis_tdata,   32'hE00);
        write_word(32'hEEE, 1'b0);
        check("ovf_flag",  32'(in_overflow), 32'd1);
        check("ovf_count", 32'(in_count),    32'd16);
        check("ovf_full",  32'(in_full),     32'd1);
        m00_axis_tready = 1'b1;
        bad = 0;
        for (int i = 0; i < 17; i++) begin
            if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== 32'hE00 + i ||
                m00_axis_tlast !== (i == 16))
                bad++;
            step();
        end
        check("drain_order",  32'(bad),             32'd0);
        check("drain_tvalid", 32'(m00_axis_tvalid), 32'd0);
        check("drain_count",  32'(in_count),        32'd0);
        repeat (2) step();

        // Simultaneous write and pop at in_count=5 (pointers already wrapped)
        m00_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) write_word(32'hF0 + i, 1'b0);
        check("simul_pre_count", 32'(in_count), 32'd5);
        in_wr_en        = 1'b1;
        in_wr_data      = 32'hF6;
        in_wr_last      = 1'b1;
        m00_axis_tready = 1'b1;
        step();
        in_wr_en        = 1'b0;
        in_wr_last      = 1'b0;
        m00_axis_tready = 1'b0;
        check("simul_count", 32'(in_count),  32'd5);
        check("simul_tdata", m00_axis_tdata, 32'hF1);
        m00_axis_tready = 1'b1;
        bad = 0;
        for (int i = 1; i < 7; i++) begin
            if (m00_axis_tvalid !== 1'b1 || m00_axis_tdata !== 32'hF0 + i ||
                m00_axis_tlast !== (i == 6))
                bad++;
            step();
        end
        check("simul_drain_order", 32'(bad), 32'd0);
        repeat (2) step();

        // Reset while a beat is held
        m00_axis_tready = 1'b0;
        write_word(32'h60, 1'b0);
        write_word(32'h61, 1'b0);
        check("hold_tvalid", 32'(m00_axis_tvalid), 32'd1);
        #2 m00_axis_areset = 1'b1;
        #1;
        check("midrst_tvalid",   32'(m00_axis_tvalid), 32'd0);
        check("midrst_count",    32'(in_count),        32'd0);
        check("midrst_overflow", 32'(in_overflow),     32'd0);
        check("midrst_tdata",    m00_axis_tdata,       32'd0);
        check("midrst_tstrb",    32'(m00_axis_tstrb),  32'hF);
        @(negedge m00_axis_aclk);
        m00_axis_areset = 1'b0;
        m00_axis_tready = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m00_axis_tvalid !== 1'b0) bad++;
        end
        check("postrst_silent", 32'(bad), 32'd0);
        m00_axis_tready = 1'b0;
        write_word(32'h70, 1'b1);
        check("postrst_tvalid", 32'(m00_axis_tvalid), 32'd1);
        check("postrst_tdata",  m00_axis_tdata,       32'h70);
        check("postrst_tlast",  32'(m00_axis_tlast),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
